// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: issues sequential fetches over a req/gnt + rvalid bus,
// buffers returned {pc, inst} pairs in a small FIFO, and flushes on core redirects.
module inst_fetch_unit #(
  parameter int unsigned          WORD_LEN = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [WORD_LEN-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [WORD_LEN-1:0] redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [WORD_LEN-1:0] inst_pc,
  output logic [WORD_LEN-1:0] inst_data,
  output logic                mem_req,
  output logic [WORD_LEN-1:0] mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t              state, state_nxt;
  logic [WORD_LEN-1:0] fetch_pc;
  logic [WORD_LEN-1:0] req_pc;
  logic [WORD_LEN-1:0] fifo_pc   [DEPTH];
  logic [WORD_LEN-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                push, pop, grant;

  assign inst_valid = (count != '0);
  assign inst_pc    = fifo_pc[rd_ptr];
  assign inst_data  = fifo_data[rd_ptr];
  assign mem_addr   = fetch_pc;
  assign grant      = mem_req & mem_gnt;
  assign pop        = inst_valid & inst_ready & ~redirect_valid;

  // mem_req is also held low while rst is asserted so the bus sees no request during reset.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    push      = 1'b0;
    case (state)
      S_REQ: begin
        mem_req = (count < CNT_W'(DEPTH)) & ~redirect_valid & ~rst;
        if (mem_req & mem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          push      = ~redirect_valid;
          state_nxt = S_REQ;
        end else if (redirect_valid) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~WORD_LEN'(3);
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (grant) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + WORD_LEN'(4);
        end
        if (push) begin
          fifo_pc[wr_ptr]   <= req_pc;
          fifo_data[wr_ptr] <= mem_rdata;
          wr_ptr            <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a random phase, all checked
// each cycle against a queue-based transaction model of the fetch stage.
module tb_inst_fetch_unit;

  localparam int unsigned WL       = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc, inst_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  inst_fetch_unit #(.WORD_LEN(WL), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory agent
  bit          pend = 1'b0;
  int unsigned pend_left = 0;
  logic [31:0] pend_addr = '0;
  int unsigned lat = 1;
  logic [31:0] gnt_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];

  // reference model: expected FIFO contents, next fetch PC, one outstanding fetch
  logic [63:0] mq[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  logic [31:0] m_out_pc = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h0010_0093 + pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit          exp_req;
    bit          grant_now;
    logic [31:0] gaddr;
    @(negedge clk);
    if (rst) begin
      chk("rst_mem_req", 32'(mem_req), 32'(0));
      mq.delete();
      m_pc = RESET_PC;
      m_out = 1'b0;
      m_stale = 1'b0;
    end else begin
      exp_req = !m_out && (mq.size() < DEPTH) && !redirect_valid;
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) chk("mem_addr", mem_addr, m_pc);
      chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("inst_pc", inst_pc, mq[0][63:32]);
        chk("inst_data", inst_data, mq[0][31:0]);
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        got_pc.push_back(inst_pc);
        got_data.push_back(inst_data);
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc & ~32'h3;
        if (m_out) begin
          if (mem_rvalid) begin m_out = 1'b0; m_stale = 1'b0; end
          else m_stale = 1'b1;
        end
      end else begin
        if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
        if (m_out && mem_rvalid) begin
          if (!m_stale) mq.push_back({m_out_pc, mem_rdata});
          m_out = 1'b0;
          m_stale = 1'b0;
        end else if (exp_req && mem_gnt) begin
          m_out = 1'b1;
          m_stale = 1'b0;
          m_out_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
    end
    grant_now = mem_req && mem_gnt;
    gaddr = mem_addr;
    @(posedge clk);
    #1;
    if (grant_now) begin
      pend = 1'b1;
      pend_left = lat;
      pend_addr = gaddr;
      gnt_q.push_back(gaddr);
    end
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    if (pend) begin
      pend_left--;
      if (pend_left == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = inst_of(pend_addr);
        pend = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    mem_gnt = 1'b0;
    pend = 1'b0;
    mem_rvalid = 1'b0;
    lat = 1;
    tick();
    tick();
    #1;
    chk("reset_inst_valid", 32'(inst_valid), 32'(0));
    chk("reset_mem_req", 32'(mem_req), 32'(0));
    chk("reset_inst_pc", inst_pc, 32'h0);
    chk("reset_inst_data", inst_data, 32'h0);
    chk("reset_mem_addr", mem_addr, RESET_PC);
    rst = 1'b0;
    gnt_q.delete();
    got_pc.delete();
    got_data.delete();
  endtask

  initial begin
    // 1: streaming fetch with always-ready consumer
    do_reset();
    mem_gnt = 1'b1; inst_ready = 1'b1; lat = 1;
    repeat (12) tick();
    chk("t1_count", 32'(got_pc.size() >= 3), 32'(1));
    for (int i = 0; i < 3; i++) begin
      chk("t1_pc", got_pc[i], 32'(4 * i));
      chk("t1_data", got_data[i], inst_of(32'(4 * i)));
    end

    // 2: backpressure fills FIFO, one pop frees one fetch
    do_reset();
    mem_gnt = 1'b1; inst_ready = 1'b0; lat = 1;
    repeat (20) tick();
    chk("t2_grants", 32'(gnt_q.size()), 32'(4));
    for (int i = 0; i < 4; i++) chk("t2_gaddr", gnt_q[i], 32'(4 * i));
    #1 chk("t2_req_idle", 32'(mem_req), 32'(0));
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    for (int k = 0; k < 10 && gnt_q.size() < 5; k++) tick();
    chk("t2_grants_after_pop", 32'(gnt_q.size()), 32'(5));
    chk("t2_next_addr", gnt_q[4], 32'h10);

    // 3: redirect while waiting on 0x8
    do_reset();
    mem_gnt = 1'b1; inst_ready = 1'b0; lat = 1;
    for (int k = 0; k < 20 && gnt_q.size() < 2; k++) tick();
    lat = 20;
    for (int k = 0; k < 20 && gnt_q.size() < 3; k++) tick();
    chk("t3_gaddr_8", gnt_q[2], 32'h8);
    tick();
    tick();
    #1 chk("t3_pre_valid", 32'(inst_valid), 32'(1));
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; lat = 1; inst_ready = 1'b1;
    #1;
    chk("t3_flush_valid", 32'(inst_valid), 32'(0));
    chk("t3_drain_req", 32'(mem_req), 32'(0));
    for (int k = 0; k < 40 && got_pc.size() < 1; k++) tick();
    chk("t3_gaddr_100", gnt_q[3], 32'h100);
    chk("t3_first_pc", got_pc[0], 32'h100);
    chk("t3_first_data", got_data[0], inst_of(32'h100));

    // 4: redirect coinciding with rvalid
    do_reset();
    mem_gnt = 1'b1; inst_ready = 1'b0; lat = 1;
    for (int k = 0; k < 20 && !(mem_rvalid && gnt_q.size() == 2); k++) tick();
    chk("t4_gcount", 32'(gnt_q.size()), 32'(2));
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_valid", 32'(inst_valid), 32'(0));
    chk("t4_req", 32'(mem_req), 32'(1));
    chk("t4_addr", mem_addr, 32'h200);
    tick();
    chk("t4_gaddr", gnt_q[2], 32'h200);
    #1 chk("t4_still_empty", 32'(inst_valid), 32'(0));

    // 5: grant stall keeps request stable
    do_reset();
    mem_gnt = 1'b0; inst_ready = 1'b1; lat = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_req_hold", 32'(mem_req), 32'(1));
      chk("t5_addr_hold", mem_addr, 32'h0);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("t5_wait_req", 32'(mem_req), 32'(0));
    chk("t5_grants", 32'(gnt_q.size()), 32'(1));

    // 6: reset in WAIT, stale response afterwards
    do_reset();
    mem_gnt = 1'b1; inst_ready = 1'b1; lat = 2;
    tick();
    chk("t6_grant", 32'(gnt_q.size()), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(inst_valid), 32'(0));
    chk("t6_req", 32'(mem_req), 32'(1));
    chk("t6_addr", mem_addr, RESET_PC);
    tick();
    #1 chk("t6_valid_after", 32'(inst_valid), 32'(0));
    got_pc.delete();
    for (int k = 0; k < 20 && got_pc.size() < 1; k++) tick();
    chk("t6_first_pc", got_pc[0], RESET_PC);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      inst_ready = ($urandom_range(3) != 0);
      mem_gnt = ($urandom_range(2) != 0);
      lat = $urandom_range(3, 1);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 32'(got_pc.size() > 50), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
